normlize_q_sequencer: RTL and testbench

//  Sequencer for the column-normalize stage in the 2x2 inverse datapath.
//  - Accepts a 2x2 matrix (two columns) over a valid/ready handshake.
//  - Feeds the columns, one at a time, into the single normalize stage.
//  - Captures the two 32-bit normalized results per column after a fixed pipeline latency.
//  - Presents the assembled normalized matrix Q downstream over valid/ready.

---
 rtl/normlize_q_sequencer.sv | 114 +++++++++++
 tb/tb_normlize_q_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/normlize_q_sequencer.sv
// normlize_q_sequencer: feeds a latched 2x2 matrix column-by-column through the normalize stage and assembles Q
module normlize_q_sequencer #(
  parameter int DATA_W       = 16,
  parameter int NORM_W       = 32,
  parameter int NORM_LATENCY = 40
) (
  input  logic              I_sys_clk,
  input  logic              I_sys_rstn,
  input  logic              I_mat_valid,
  output logic              O_mat_ready,
  input  logic [DATA_W-1:0] I_a_1_1,
  input  logic [DATA_W-1:0] I_a_1_2,
  input  logic [DATA_W-1:0] I_a_2_1,
  input  logic [DATA_W-1:0] I_a_2_2,
  output logic              O_normlize_ena,
  output logic [DATA_W-1:0] O_w_1,
  output logic [DATA_W-1:0] O_w_2,
  input  logic [NORM_W-1:0] I_w_1_normalize,
  input  logic [NORM_W-1:0] I_w_2_normalize,
  output logic              O_q_valid,
  input  logic              I_q_ready,
  output logic [NORM_W-1:0] O_q_1_1,
  output logic [NORM_W-1:0] O_q_1_2,
  output logic [NORM_W-1:0] O_q_2_1,
  output logic [NORM_W-1:0] O_q_2_2,
  output logic [1:0]        O_zero_col,
  output logic              O_busy
);
  localparam int CW = $clog2(NORM_LATENCY);
  localparam logic [CW-1:0] LAST = CW'(NORM_LATENCY - 1);
  typedef enum logic [2:0] {IDLE, RUN1, GAP, RUN2, DONE} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] a11_q, a11_d, a12_q, a12_d, a21_q, a21_d, a22_q, a22_d;
  logic [NORM_W-1:0] q11_q, q11_d, q12_q, q12_d, q21_q, q21_d, q22_q, q22_d;
  logic [1:0]        zc_q, zc_d;
  logic              ena_q, ena_d, q_valid_q, q_valid_d;
  logic [DATA_W-1:0] w1_q, w1_d, w2_q, w2_d;
  logic              accept, running, run_end;
  assign accept  = I_mat_valid && (state_q == IDLE);
  assign running = (state_q == RUN1) || (state_q == RUN2);
  assign run_end = running && (cnt_q == LAST);
  // next state, counter, latched matrix, captured Q and the registered stage/handshake outputs
  always_comb begin
    case (state_q)
      IDLE:    state_d = accept ? RUN1 : IDLE;
      RUN1:    state_d = run_end ? GAP : RUN1;
      GAP:     state_d = RUN2;
      RUN2:    state_d = run_end ? DONE : RUN2;
      DONE:    state_d = I_q_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    cnt_d = (running && !run_end) ? cnt_q + 1'b1 : '0;
    a11_d = accept ? I_a_1_1 : a11_q;
    a12_d = accept ? I_a_1_2 : a12_q;
    a21_d = accept ? I_a_2_1 : a21_q;
    a22_d = accept ? I_a_2_2 : a22_q;
    zc_d  = accept ? {(I_a_1_2 == '0) && (I_a_2_2 == '0), (I_a_1_1 == '0) && (I_a_2_1 == '0)} : zc_q;
    q11_d = (run_end && state_q == RUN1) ? (zc_q[0] ? '0 : I_w_1_normalize) : q11_q;
    q21_d = (run_end && state_q == RUN1) ? (zc_q[0] ? '0 : I_w_2_normalize) : q21_q;
    q12_d = (run_end && state_q == RUN2) ? (zc_q[1] ? '0 : I_w_1_normalize) : q12_q;
    q22_d = (run_end && state_q == RUN2) ? (zc_q[1] ? '0 : I_w_2_normalize) : q22_q;
    ena_d     = (state_d == RUN1) || (state_d == RUN2);
    w1_d      = (state_d == RUN1) ? a11_d : (state_d == RUN2) ? a12_d : '0;
    w2_d      = (state_d == RUN1) ? a21_d : (state_d == RUN2) ? a22_d : '0;
    q_valid_d = state_d == DONE;
  end
  // all state lives here; reset aborts any run immediately
  always_ff @(posedge I_sys_clk or negedge I_sys_rstn)
    if (!I_sys_rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a11_q     <= '0;
      a12_q     <= '0;
      a21_q     <= '0;
      a22_q     <= '0;
      zc_q      <= '0;
      q11_q     <= '0;
      q12_q     <= '0;
      q21_q     <= '0;
      q22_q     <= '0;
      ena_q     <= 1'b0;
      w1_q      <= '0;
      w2_q      <= '0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a11_q     <= a11_d;
      a12_q     <= a12_d;
      a21_q     <= a21_d;
      a22_q     <= a22_d;
      zc_q      <= zc_d;
      q11_q     <= q11_d;
      q12_q     <= q12_d;
      q21_q     <= q21_d;
      q22_q     <= q22_d;
      ena_q     <= ena_d;
      w1_q      <= w1_d;
      w2_q      <= w2_d;
      q_valid_q <= q_valid_d;
    end
  assign O_mat_ready    = state_q == IDLE;
  assign O_busy         = state_q != IDLE;
  assign O_normlize_ena = ena_q;
  assign O_w_1          = w1_q;
  assign O_w_2          = w2_q;
  assign O_q_valid      = q_valid_q;
  assign O_q_1_1        = q11_q;
  assign O_q_1_2        = q12_q;
  assign O_q_2_1        = q21_q;
  assign O_q_2_2        = q22_q;
  assign O_zero_col     = zc_q;
endmodule

// File: tb/tb_normlize_q_sequencer.sv
// tb_normlize_q_sequencer: scoreboard bench with a behavioural normalize-stage stub
module tb_normlize_q_sequencer;
  localparam int L = 4;
  typedef struct packed {
    logic [31:0] q11, q21, q12, q22;
    logic [1:0]  zc;
  } exp_t;
  logic        clk = 0, rstn = 0, mat_valid = 0, q_ready = 0;
  logic [15:0] a11 = 0, a12 = 0, a21 = 0, a22 = 0;
  logic        mat_ready, ena, q_valid, busy;
  logic [15:0] w1, w2;
  logic [31:0] w1n, w2n, q11, q12, q21, q22;
  logic [1:0]  zc;
  int          checks = 0, failures = 0, cyc = 0, scnt = 0;
  logic [15:0] d1, d2;
  exp_t        sb[$];
  normlize_q_sequencer #(.DATA_W(16), .NORM_W(32), .NORM_LATENCY(L)) dut (
    .I_sys_clk(clk), .I_sys_rstn(rstn), .I_mat_valid(mat_valid), .O_mat_ready(mat_ready),
    .I_a_1_1(a11), .I_a_1_2(a12), .I_a_2_1(a21), .I_a_2_2(a22),
    .O_normlize_ena(ena), .O_w_1(w1), .O_w_2(w2),
    .I_w_1_normalize(w1n), .I_w_2_normalize(w2n),
    .O_q_valid(q_valid), .I_q_ready(q_ready),
    .O_q_1_1(q11), .O_q_1_2(q12), .O_q_2_1(q21), .O_q_2_2(q22),
    .O_zero_col(zc), .O_busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // a/|col| in Q16.16; dividend is taken at the first enabled edge, divisor from the live inputs
  function automatic logic [31:0] nrm(input logic [15:0] a, input logic [15:0] x, input logic [15:0] y);
    real m;
    m = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    if (m == 0.0) return 32'hBAD0_0000;
    return 32'($rtoi($floor(real'(a) * 65536.0 / m)));
  endfunction
  // stage stub: counts enabled edges, result valid once L-1 have been seen, garbage before
  always @(posedge clk or negedge rstn)
    if (!rstn) scnt <= 0;
    else if (ena) begin
      if (scnt == 0) begin
        d1 <= w1;
        d2 <= w2;
      end
      scnt <= scnt + 1;
    end else scnt <= 0;
  always_comb begin
    w1n = (scnt >= L - 1) ? nrm(d1, w1, w2) : 32'hDEAD_BEEF;
    w2n = (scnt >= L - 1) ? nrm(d2, w1, w2) : 32'hDEAD_BEEF;
  end
  function automatic exp_t model(input logic [15:0] x11, input logic [15:0] x21, input logic [15:0] x12, input logic [15:0] x22);
    exp_t e;
    e.zc  = {(x12 == 0) && (x22 == 0), (x11 == 0) && (x21 == 0)};
    e.q11 = e.zc[0] ? 32'd0 : nrm(x11, x11, x21);
    e.q21 = e.zc[0] ? 32'd0 : nrm(x21, x11, x21);
    e.q12 = e.zc[1] ? 32'd0 : nrm(x12, x12, x22);
    e.q22 = e.zc[1] ? 32'd0 : nrm(x22, x12, x22);
    return e;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // offers a matrix until accepted; returns the accepting edge index and pushes the expected Q
  task automatic send(input logic [15:0] x11, input logic [15:0] x21, input logic [15:0] x12, input logic [15:0] x22, output int acc);
    a11 = x11; a21 = x21; a12 = x12; a22 = x22; mat_valid = 1; acc = -1;
    for (int i = 0; i < 200; i++) begin
      if (mat_ready) begin
        tick;
        acc = cyc;
        sb.push_back(model(x11, x21, x12, x22));
        mat_valid = 0;
        return;
      end
      tick;
    end
    mat_valid = 0;
    checks++; failures++;
    $display("FAIL send_timeout got=mat_ready_low exp=accept within 200 cycles");
  endtask
  // waits for O_q_valid, returns the presented Q and the edge index it appeared at
  task automatic collect(output exp_t got, output int vc);
    got = '0; vc = -1;
    for (int i = 0; i < 100; i++) begin
      if (q_valid) begin
        got = {q11, q21, q12, q22, zc};
        vc = cyc;
        return;
      end
      tick;
    end
    checks++; failures++;
    $display("FAIL collect_timeout got=q_valid_low exp=q_valid within 100 cycles");
  endtask
  task automatic release_q;
    q_ready = 1;
    tick;
    q_ready = 0;
  endtask
  task automatic test_reset;
    tick; tick;
    checks++;
    if ({ena, w1, w2, q_valid, q11, q21, q12, q22, zc, busy} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", {ena, w1, w2, q_valid, q11, q21, q12, q22, zc, busy});
    end
    checks++;
    if (mat_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", mat_ready); end
    rstn = 1;
    tick;
  endtask
  task automatic test_basic;
    int acc, vc;
    logic [9:0] ena_v, val_v;
    exp_t got, e;
    send(16'd3, 16'd4, 16'd0, 16'd5, acc);
    for (int k = 0; k < 10; k++) begin
      ena_v[k] = ena;
      val_v[k] = q_valid;
      if (k < 9) tick;
    end
    checks++;
    if (ena_v !== 10'b0111101111) begin failures++; $display("FAIL basic_ena got=%b exp=%b", ena_v, 10'b0111101111); end
    checks++;
    if (val_v !== 10'b1000000000) begin failures++; $display("FAIL basic_valid got=%b exp=%b", val_v, 10'b1000000000); end
    collect(got, vc);
    checks++;
    if (vc - acc !== 9) begin failures++; $display("FAIL basic_latency got=%0d exp=9", vc - acc); end
    checks++;
    if (got !== {32'h0000_9999, 32'h0000_CCCC, 32'h0, 32'h0001_0000, 2'b00}) begin
      failures++; $display("FAIL basic_const got=%h exp=%h", got, {32'h0000_9999, 32'h0000_CCCC, 32'h0, 32'h0001_0000, 2'b00});
    end
    e = sb.pop_front();
    checks++;
    if (got !== e) begin failures++; $display("FAIL basic_sb got=%h exp=%h", got, e); end
    release_q;
  endtask
  task automatic test_zero_col;
    int acc, vc;
    exp_t got, e;
    send(16'd1, 16'd2, 16'd0, 16'd0, acc);
    checks++;
    if (zc !== 2'b10) begin failures++; $display("FAIL zero_flag_at_accept got=%b exp=10", zc); end
    collect(got, vc);
    checks++;
    if (vc - acc !== 9) begin failures++; $display("FAIL zero_latency got=%0d exp=9", vc - acc); end
    e = sb.pop_front();
    checks++;
    if (got !== e) begin failures++; $display("FAIL zero_sb got=%h exp=%h", got, e); end
    release_q;
  endtask
  task automatic test_backpressure;
    int acc, vc;
    logic ok;
    exp_t got, e;
    send(16'd5, 16'd12, 16'd8, 16'd6, acc);
    collect(got, vc);
    ok = 1;
    repeat (20) begin
      tick;
      ok &= (q_valid === 1'b1) && ({q11, q21, q12, q22, zc} === got) && (mat_ready === 1'b0);
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_hold got=ok_%b exp=ok_1", ok); end
    e = sb.pop_front();
    checks++;
    if (got !== e) begin failures++; $display("FAIL bp_sb got=%h exp=%h", got, e); end
    release_q;
    checks++;
    if ({q_valid, mat_ready} !== 2'b01) begin failures++; $display("FAIL bp_release got=%b exp=01", {q_valid, mat_ready}); end
  endtask
  task automatic test_valid_ignored;
    int acc, vc;
    logic ok_w, ok_rdy;
    exp_t got, e;
    send(16'd2, 16'd3, 16'd7, 16'd1, acc);
    ok_w = 1; ok_rdy = 1;
    for (int k = 0; k < 9; k++) begin
      if (k < 4) ok_w &= (w1 === 16'd2) && (w2 === 16'd3) && (ena === 1'b1);
      else if (k == 4) ok_w &= (w1 === 16'd0) && (w2 === 16'd0) && (ena === 1'b0);
      else ok_w &= (w1 === 16'd7) && (w2 === 16'd1) && (ena === 1'b1);
      ok_rdy &= (mat_ready === 1'b0) && (busy === 1'b1) && (q_valid === 1'b0);
      mat_valid = k[0];
      a11 = 16'($urandom); a12 = 16'($urandom); a21 = 16'($urandom); a22 = 16'($urandom);
      tick;
    end
    mat_valid = 0;
    checks++;
    if (!ok_w) begin failures++; $display("FAIL vi_w_const got=ok_%b exp=ok_1", ok_w); end
    checks++;
    if (!ok_rdy) begin failures++; $display("FAIL vi_no_accept got=ok_%b exp=ok_1", ok_rdy); end
    collect(got, vc);
    checks++;
    if (vc - acc !== 9) begin failures++; $display("FAIL vi_latency got=%0d exp=9", vc - acc); end
    e = sb.pop_front();
    checks++;
    if (got !== e) begin failures++; $display("FAIL vi_sb got=%h exp=%h", got, e); end
    release_q;
  endtask
  task automatic test_reset_mid;
    int acc, vc;
    exp_t got, e;
    send(16'd3, 16'd4, 16'd6, 16'd8, acc);
    repeat (7) tick;
    rstn = 0;
    #1;
    checks++;
    if ({ena, w1, w2, q_valid, q11, q21, q12, q22, zc, busy} !== '0 || mat_ready !== 1'b1) begin
      failures++; $display("FAIL midreset_outputs got=%h ready=%b exp=0 ready=1", {ena, w1, w2, q_valid, q11, q21, q12, q22, zc, busy}, mat_ready);
    end
    e = sb.pop_front();
    tick;
    rstn = 1;
    tick;
    send(16'd6, 16'd8, 16'd3, 16'd4, acc);
    collect(got, vc);
    checks++;
    if (vc - acc !== 9) begin failures++; $display("FAIL midreset_latency got=%0d exp=9", vc - acc); end
    e = sb.pop_front();
    checks++;
    if (got !== e) begin failures++; $display("FAIL midreset_sb got=%h exp=%h", got, e); end
    release_q;
  endtask
  task automatic test_back_to_back;
    int acc[4];
    int n;
    exp_t got, e;
    logic [63:0] mats[4];
    mats[0] = 64'h0000_0000_0007_0000;
    mats[1] = 64'h000C_0005_0008_000F;
    mats[2] = 64'h0001_0001_0000_0009;
    mats[3] = 64'h0000_0000_0000_0000;
    n = 0;
    q_ready = 1;
    fork
      for (int i = 0; i < 4; i++) send(mats[i][63:48], mats[i][47:32], mats[i][31:16], mats[i][15:0], acc[i]);
      begin
        for (int c = 0; c < 200 && n < 4; c++) begin
          tick;
          if (q_valid) begin
            got = {q11, q21, q12, q22, zc};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin failures++; $display("FAIL b2b_sb%0d got=%h exp=%h", n, got, e); end
            n++;
          end
        end
        if (n < 4) begin checks++; failures++; $display("FAIL b2b_timeout got=%0d exp=4 results", n); end
      end
    join
    q_ready = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (acc[i+1] - acc[i] !== 11) begin failures++; $display("FAIL b2b_spacing%0d got=%0d exp=11", i, acc[i+1] - acc[i]); end
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_zero_col;
    test_backpressure;
    test_valid_ignored;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
